hififo_fetch_descriptor_mc: RTL and testbench
=============================================

# hififo_fetch_descriptor_mc

Multi-channel descriptor fetch engine for the HIFIFO PCIe-to-FIFO DMA path. Each of NCH channels holds a host ring (issue/done/stop/interrupt pointers, high address, abort). A round-robin arbiter merges their fetch requests onto one tagged request port. A per-channel outstanding limit applies, with completion-based interrupts. It sits between the register-write decoder and the PCIe read-request generator. It replaces per-channel single fetchers where several FIFOs share one read engine.

## Interface
- NCH, 4: number of channels, 1..16.
- CHW, 2: channel index width, at least 1, with 2^CHW ≥ NCH.
- BS, 8: address LSBs ignored, so pointer granularity is 2^BS bytes; must be ≥ 8.
- AMSB, 63: request address MSB.
- DMSB, 63: write data MSB.
- SMSB, 31: status MSB; must be ≥ CMSB.
- CBITS, 22: ring offset bits; CMSB = CBITS-1, and pointer width PW = CBITS-BS.
- MAXOUT, 4: maximum outstanding fetches per channel, 1..15.

Ports:
- clock, input, 1: sole clock.
- reset, input, 1: synchronous, active-high.
- request_addr, output, AMSB+1: {addr_high[ch], p_issue[ch], BS zeros}; registered.
- request_tag, output, CHW: channel of the presented request; registered.
- request_valid, output, 1: request presented; registered.
- request_ack, input, 1: request accepted; meaningful only while request_valid is high.
- done_valid, input, 1: one fetch completed.
- done_chan, input, CHW: channel of the completion.
- wdata, input, DMSB+1: command word.
- wvalid, input, 1: wdata is valid this cycle.
- status_sel, input, CHW: channel selected for status.
- status, output, SMSB+1: {p_done[status_sel], BS zeros}, zero-extended; registered.
- interrupt, output, NCH: per-channel one-cycle pulse.

## Operation
- Commands are taken when wvalid is high. The opcode is wdata[2:0] and the channel is wdata[4 +: CHW]; a channel ≥ NCH is ignored.
  - Opcode 1 sets p_interrupt = wdata[CMSB:BS].
  - Opcode 2 sets p_stop = wdata[CMSB:BS].
  - Opcode 3 sets addr_high = wdata[AMSB:CBITS].
  - Opcode 4 sets abort = wdata[8].
  - Any other opcode is ignored.
- Per-channel state:
  - p_issue, p_done and p_stop are PW bits and wrap modulo 2^PW.
  - outs is 4 bits and counts outstanding fetches.
  - abort resets to 1.
  - p_interrupt and addr_high are not reset.
- Abort:
  - While abort is 1, p_issue, p_done, p_stop and outs are held at 0.
  - Completions for an aborted channel are dropped.
  - Aborting the channel currently presented does not withdraw the request. Its ack completes the handshake but changes no counters.
- Eligibility: a channel is eligible when abort = 0, p_issue != p_stop and outs < MAXOUT.
- Arbitration:
  - While no request is presented, the lowest eligible channel after the last granted channel (circularly) is latched into request_addr and request_tag, and request_valid rises.
  - After reset, the last granted channel is NCH-1, so channel 0 has first priority.
- On ack (request_valid && request_ack):
  - p_issue[tag] increments and outs[tag] increments.
  - request_valid drops the next cycle.
- Completion: done_valid on a non-aborted channel with outs > 0 increments p_done and decrements outs. A completion with outs = 0 is ignored.
- Ack and done on the same channel in the same cycle leave outs unchanged; both pointers still advance.
- Interrupt:
  - eq[ch] = (p_done == p_interrupt) is registered every cycle.
  - interrupt[ch] = eq && !eq_prev. eq_prev resets to 1, so there is no pulse out of reset.
  - Writing p_interrupt equal to the current p_done pulses once.

## Timing
- Reset values: request_valid 0, request_tag 0, request_addr 0, status 0, interrupt 0, all aborts 1.
- Request issue:
  - Eligibility in cycle N gives request_valid high in cycle N+1.
  - Outputs are held stable until ack.
  - After an ack in cycle N, request_valid is 0 in N+1, and the next request is presented at earliest N+2.
- Command effect: a command write in cycle N is visible in state at N+1 and can affect a request presented at N+2.
- Status latency: 1 cycle from status_sel or p_done.
- Interrupt latency: a done in cycle N makes p_done match in N+1, and interrupt pulses in N+2.
- Reset has priority over every command and handshake. Reset asserted mid-handshake drops request_valid the next cycle, and any outstanding completions are ignored because outs is 0.

## Test plan
- Single channel, basic fetch:
  - Stimulus: reset; channel 0 abort=0, addr_high=0x12, stop=3; ack every presented request.
  - Required response: three requests with tag 0, addresses 0x12<<22 | 0x000, 0x100, 0x200, each followed by an idle cycle; then valid stays low.
- Outstanding limit:
  - Stimulus: MAXOUT=4, stop=10, no completions.
  - Required response: exactly 4 acks, then stall.
  - Stimulus: one done.
  - Required response: exactly one more request.
- Round robin:
  - Stimulus: channels 0, 1, 2 all eligible; continuous acks.
  - Required response: tags 0, 1, 2, 0, 1, 2.
  - Stimulus: abort channel 1.
  - Required response: tags 0, 2, 0, 2.
- Interrupt and wrap:
  - Stimulus: PW=14; set p_interrupt=0; drive 2^14 issues and completions.
  - Required response: p_done wraps to 0 and exactly one interrupt[0] pulse occurs, 2 cycles after the final done. Status reads 0 after the wrap.
- Same-cycle ack and done:
  - Stimulus: ack and done on the same channel with outs=2.
  - Required response: outs stays 2; p_issue and p_done each advance by 1.
- Abort mid-request:
  - Stimulus: abort the presented channel; ack 3 cycles later.
  - Required response: request_valid is held until the ack; all of that channel's counters read 0 afterwards and the channel is no longer requested.

Source files
------------

// File: rtl/hififo_fetch_descriptor_mc.sv
// Multi-channel descriptor fetch engine: per-channel host rings feeding
// one tagged read-request port through a round-robin arbiter.
module hififo_fetch_descriptor_mc #(
    parameter int NCH    = 4,
    parameter int CHW    = 2,
    parameter int BS     = 8,
    parameter int AMSB   = 63,
    parameter int DMSB   = 63,
    parameter int SMSB   = 31,
    parameter int CBITS  = 22,
    parameter int MAXOUT = 4
) (
    input  logic            clock,
    input  logic            reset,
    output logic [AMSB:0]   request_addr,
    output logic [CHW-1:0]  request_tag,
    output logic            request_valid,
    input  logic            request_ack,
    input  logic            done_valid,
    input  logic [CHW-1:0]  done_chan,
    input  logic [DMSB:0]   wdata,
    input  logic            wvalid,
    input  logic [CHW-1:0]  status_sel,
    output logic [SMSB:0]   status,
    output logic [NCH-1:0]  interrupt
);

    localparam int CMSB = CBITS - 1;
    localparam int PW   = CBITS - BS;
    localparam int HW   = AMSB + 1 - CBITS;
    localparam int SW   = SMSB + 1;

    localparam logic [2:0] OP_INT   = 3'd1;
    localparam logic [2:0] OP_STOP  = 3'd2;
    localparam logic [2:0] OP_HIGH  = 3'd3;
    localparam logic [2:0] OP_ABORT = 3'd4;

    logic [PW-1:0]  p_issue [NCH];
    logic [PW-1:0]  p_done  [NCH];
    logic [PW-1:0]  p_stop  [NCH];
    logic [PW-1:0]  p_int   [NCH];
    logic [3:0]     outs    [NCH];
    logic [HW-1:0]  addr_high [NCH];

    logic [NCH-1:0] abort, abort_n, eq, eq_prev, elig;
    logic [NCH-1:0] hit, ack_c, done_c;
    logic [2:0]     op;
    logic [CHW-1:0] cmd_ch, last, pick;
    logic [AMSB:0]  pick_addr;
    logic [PW-1:0]  sel_done;
    logic           found, acked;

    assign op        = wdata[2:0];
    assign cmd_ch    = wdata[4 +: CHW];
    assign acked     = request_valid && request_ack;
    assign interrupt = eq & ~eq_prev;

    always_comb begin
        sel_done = '0;
        for (int c = 0; c < NCH; c++) begin
            hit[c]     = wvalid && (cmd_ch == CHW'(c));
            abort_n[c] = (hit[c] && op == OP_ABORT) ? wdata[8] : abort[c];
            // Acks for an aborted channel finish the handshake only
            ack_c[c]   = acked && (request_tag == CHW'(c)) && !abort[c];
            done_c[c]  = done_valid && (done_chan == CHW'(c))
                         && !abort[c] && (outs[c] != 4'd0);
            elig[c]    = !abort[c] && (p_issue[c] != p_stop[c])
                         && (outs[c] < 4'(MAXOUT));
            if (status_sel == CHW'(c)) sel_done = p_done[c];
        end
    end

    always_comb begin : arb
        int j;
        logic [CHW-1:0] k;
        found     = 1'b0;
        pick      = '0;
        pick_addr = '0;
        for (int i = 1; i <= NCH; i++) begin
            j = (int'(last) + i) % NCH;
            k = CHW'(j);
            if (!found && elig[k]) begin
                found     = 1'b1;
                pick      = k;
                pick_addr = {addr_high[k], p_issue[k], {BS{1'b0}}};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            abort   <= '1;
            eq      <= '1;
            eq_prev <= '1;
            for (int c = 0; c < NCH; c++) begin
                p_issue[c] <= '0;
                p_done[c]  <= '0;
                p_stop[c]  <= '0;
                outs[c]    <= '0;
            end
        end else begin
            abort   <= abort_n;
            eq_prev <= eq;
            for (int c = 0; c < NCH; c++) begin
                eq[c] <= (p_done[c] == p_int[c]);
                if (abort_n[c]) begin
                    p_issue[c] <= '0;
                    p_done[c]  <= '0;
                    p_stop[c]  <= '0;
                    outs[c]    <= '0;
                end else begin
                    if (hit[c] && op == OP_STOP)
                        p_stop[c] <= wdata[CMSB:BS];
                    if (ack_c[c])
                        p_issue[c] <= p_issue[c] + PW'(1);
                    if (done_c[c])
                        p_done[c] <= p_done[c] + PW'(1);
                    if (ack_c[c] && !done_c[c])
                        outs[c] <= outs[c] + 4'd1;
                    else if (done_c[c] && !ack_c[c])
                        outs[c] <= outs[c] - 4'd1;
                end
            end
        end
    end

    // Interrupt pointer and high address are deliberately left unreset
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int c = 0; c < NCH; c++) begin
                if (hit[c] && op == OP_INT)
                    p_int[c] <= wdata[CMSB:BS];
                if (hit[c] && op == OP_HIGH)
                    addr_high[c] <= wdata[AMSB:CBITS];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            request_valid <= 1'b0;
            request_tag   <= '0;
            request_addr  <= '0;
            last          <= CHW'(NCH - 1);
            status        <= '0;
        end else begin
            status <= SW'({sel_done, {BS{1'b0}}});
            if (request_valid) begin
                if (request_ack) request_valid <= 1'b0;
            end else if (found) begin
                request_valid <= 1'b1;
                request_tag   <= pick;
                request_addr  <= pick_addr;
                last          <= pick;
            end
        end
    end

endmodule

// File: tb/tb_hififo_fetch_descriptor_mc.sv
// Directed self-checking bench for hififo_fetch_descriptor_mc.
// Inputs and samples both happen on the falling clock edge.
module tb_hififo_fetch_descriptor_mc;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] request_addr;
    logic [1:0]  request_tag;
    logic        request_valid;
    logic        request_ack = 1'b0;
    logic        done_valid = 1'b0;
    logic [1:0]  done_chan = 2'd0;
    logic [63:0] wdata = 64'd0;
    logic        wvalid = 1'b0;
    logic [1:0]  status_sel = 2'd0;
    logic [31:0] status;
    logic [3:0]  interrupt;

    int checks = 0;
    int errors = 0;
    bit cnt_en = 1'b0;
    int pulses = 0;

    hififo_fetch_descriptor_mc dut (
        .clock(clock),
        .reset(reset),
        .request_addr(request_addr),
        .request_tag(request_tag),
        .request_valid(request_valid),
        .request_ack(request_ack),
        .done_valid(done_valid),
        .done_chan(done_chan),
        .wdata(wdata),
        .wvalid(wvalid),
        .status_sel(status_sel),
        .status(status),
        .interrupt(interrupt)
    );

    always #5 clock = ~clock;

    always @(negedge clock)
        if (cnt_en && interrupt[0]) pulses++;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic wr(input logic [2:0] op, input int ch, input logic [63:0] v);
        wdata  = v | 64'(op) | (64'(ch) << 4);
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        wdata  = 64'd0;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        request_ack = 1'b0;
        done_valid  = 1'b0;
        wvalid      = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_req(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (request_valid) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic ack_one();
        request_ack = 1'b1;
        tick();
        request_ack = 1'b0;
    endtask

    task automatic drain(input int budget, output int n);
        int idle;
        idle = 0;
        n = 0;
        while (idle < budget) begin
            if (request_valid) begin
                n++;
                ack_one();
                idle = 0;
            end else begin
                tick();
                idle++;
            end
        end
    endtask

    task automatic setup(input int ch, input int high, input int stop);
        wr(3'd4, ch, 64'd0);
        wr(3'd3, ch, 64'(high) << 22);
        wr(3'd2, ch, 64'(stop) << 8);
    endtask

    task automatic test_reset();
        bit seen;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (request_valid !== 1'b0) begin
            errors++; $display("FAIL rst_valid: got %b want 0", request_valid);
        end
        checks++;
        if (request_tag !== 2'd0) begin
            errors++; $display("FAIL rst_tag: got %0d want 0", request_tag);
        end
        checks++;
        if (request_addr !== 64'd0) begin
            errors++; $display("FAIL rst_addr: got %h want 0", request_addr);
        end
        checks++;
        if (status !== 32'd0) begin
            errors++; $display("FAIL rst_status: got %h want 0", status);
        end
        checks++;
        if (interrupt !== 4'd0) begin
            errors++; $display("FAIL rst_irq: got %b want 0", interrupt);
        end
        reset = 1'b0;
        wr(3'd2, 0, 64'd5 << 8);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (request_valid || interrupt != 4'd0) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL rst_abort: got activity want none");
        end
    endtask

    task automatic test_basic();
        bit seen;
        logic [63:0] exp;
        do_reset();
        setup(0, 'h12, 3);
        checks++;
        if (request_valid !== 1'b0) begin
            errors++; $display("FAIL basic_early: got %b want 0", request_valid);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            exp = (64'h12 << 22) | (64'(i) << 8);
            checks++;
            if (request_valid !== 1'b1 || request_tag !== 2'd0
                || request_addr !== exp) begin
                errors++;
                $display("FAIL basic_req%0d: got v=%b t=%0d a=%h want v=1 t=0 a=%h",
                         i, request_valid, request_tag, request_addr, exp);
            end
            ack_one();
            checks++;
            if (request_valid !== 1'b0) begin
                errors++; $display("FAIL basic_idle%0d: got %b want 0", i, request_valid);
            end
            tick();
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (request_valid) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL basic_stop: got extra request want none");
        end
    endtask

    task automatic test_outstanding();
        int n;
        do_reset();
        setup(0, 0, 10);
        drain(6, n);
        checks++;
        if (n != 4) begin
            errors++; $display("FAIL out_limit: got %0d acks want 4", n);
        end
        done_chan  = 2'd0;
        done_valid = 1'b1;
        tick();
        done_valid = 1'b0;
        drain(6, n);
        checks++;
        if (n != 1) begin
            errors++; $display("FAIL out_refill: got %0d acks want 1", n);
        end
        status_sel = 2'd0;
        tick();
        checks++;
        if (status !== 32'h100) begin
            errors++; $display("FAIL out_status: got %h want 00000100", status);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int exp1 [6] = '{0, 1, 2, 0, 1, 2};
        int exp2 [4] = '{0, 2, 0, 2};
        do_reset();
        wr(3'd4, 0, 64'd0);
        wr(3'd4, 1, 64'd0);
        wr(3'd4, 2, 64'd0);
        wr(3'd2, 0, 64'd10 << 8);
        wr(3'd2, 1, 64'd10 << 8);
        wr(3'd2, 2, 64'd10 << 8);
        for (int i = 0; i < 6; i++) begin
            wait_req(4, ok);
            checks++;
            if (!ok || request_tag !== 2'(exp1[i])) begin
                errors++;
                $display("FAIL rr_tag%0d: got v=%b t=%0d want t=%0d",
                         i, ok, request_tag, exp1[i]);
            end
            ack_one();
        end
        wr(3'd4, 1, 64'h100);
        for (int i = 0; i < 4; i++) begin
            wait_req(4, ok);
            checks++;
            if (!ok || request_tag !== 2'(exp2[i])) begin
                errors++;
                $display("FAIL rr_abort_tag%0d: got v=%b t=%0d want t=%0d",
                         i, ok, request_tag, exp2[i]);
            end
            ack_one();
        end
    endtask

    task automatic test_same_cycle();
        bit ok;
        int n;
        do_reset();
        setup(0, 0, 10);
        for (int i = 0; i < 2; i++) begin
            wait_req(4, ok);
            ack_one();
        end
        wait_req(4, ok);
        checks++;
        if (!ok || request_addr[21:0] !== 22'h200) begin
            errors++; $display("FAIL same_pre: got %h want 200", request_addr[21:0]);
        end
        done_chan   = 2'd0;
        request_ack = 1'b1;
        done_valid  = 1'b1;
        tick();
        request_ack = 1'b0;
        done_valid  = 1'b0;
        wait_req(4, ok);
        checks++;
        if (!ok || request_addr[21:0] !== 22'h300) begin
            errors++; $display("FAIL same_issue: got %h want 300", request_addr[21:0]);
        end
        drain(6, n);
        checks++;
        if (n != 2) begin
            errors++; $display("FAIL same_outs: got %0d acks want 2", n);
        end
        checks++;
        if (status !== 32'h100) begin
            errors++; $display("FAIL same_done: got %h want 00000100", status);
        end
    endtask

    task automatic test_abort_mid();
        bit ok;
        bit seen;
        logic [63:0] held;
        do_reset();
        setup(0, 5, 5);
        wait_req(4, ok);
        ack_one();
        done_chan  = 2'd0;
        done_valid = 1'b1;
        tick();
        done_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (status !== 32'h100) begin
            errors++; $display("FAIL abort_pre_status: got %h want 00000100", status);
        end
        wait_req(4, ok);
        held = (64'd5 << 22) | 64'h100;
        checks++;
        if (!ok || request_addr !== held) begin
            errors++; $display("FAIL abort_pre_addr: got %h want %h", request_addr, held);
        end
        wr(3'd4, 0, 64'h100);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (request_valid !== 1'b1 || request_addr !== held
                || request_tag !== 2'd0) begin
                errors++;
                $display("FAIL abort_hold%0d: got v=%b a=%h want v=1 a=%h",
                         k, request_valid, request_addr, held);
            end
            if (k < 2) tick();
        end
        ack_one();
        checks++;
        if (request_valid !== 1'b0) begin
            errors++; $display("FAIL abort_drop: got %b want 0", request_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (request_valid) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL abort_quiet: got request want none");
        end
        checks++;
        if (status !== 32'd0) begin
            errors++; $display("FAIL abort_status: got %h want 0", status);
        end
        wr(3'd4, 0, 64'd0);
        wr(3'd2, 0, 64'd3 << 8);
        wait_req(4, ok);
        checks++;
        if (!ok || request_addr !== (64'd5 << 22)) begin
            errors++;
            $display("FAIL abort_restart: got v=%b a=%h want %h",
                     ok, request_addr, 64'd5 << 22);
        end
        ack_one();
    endtask

    task automatic test_interrupt_wrap();
        bit ok;
        bit lost;
        do_reset();
        done_chan  = 2'd0;
        status_sel = 2'd0;
        wr(3'd4, 0, 64'd0);
        wr(3'd1, 0, 64'd0);
        wr(3'd3, 0, 64'd0);
        wr(3'd2, 0, 64'h2000 << 8);
        tick();
        tick();
        pulses = 0;
        cnt_en = 1'b1;
        lost   = 1'b0;
        wait_req(4, ok);
        if (!ok) lost = 1'b1;
        ack_one();
        for (int i = 1; i < 16384 && !lost; i++) begin
            wait_req(4, ok);
            if (!ok) lost = 1'b1;
            request_ack = 1'b1;
            done_valid  = 1'b1;
            if (i == 100) begin
                wdata  = 64'd2;
                wvalid = 1'b1;
            end
            tick();
            request_ack = 1'b0;
            done_valid  = 1'b0;
            wvalid      = 1'b0;
            wdata       = 64'd0;
        end
        checks++;
        if (lost) begin
            errors++; $display("FAIL wrap_stream: got stall want 16384 requests");
        end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL wrap_early_irq: got %0d want 0", pulses);
        end
        done_valid = 1'b1;
        tick();
        done_valid = 1'b0;
        checks++;
        if (status !== 32'h003FFF00 || interrupt[0] !== 1'b0) begin
            errors++;
            $display("FAIL wrap_before: got s=%h i=%b want s=003fff00 i=0",
                     status, interrupt[0]);
        end
        tick();
        checks++;
        if (status !== 32'd0 || interrupt[0] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_irq: got s=%h i=%b want s=0 i=1",
                     status, interrupt[0]);
        end
        for (int i = 0; i < 4; i++) tick();
        cnt_en = 1'b0;
        checks++;
        if (pulses != 1) begin
            errors++; $display("FAIL wrap_pulses: got %0d want 1", pulses);
        end
        checks++;
        if (request_valid !== 1'b0) begin
            errors++; $display("FAIL wrap_stop: got %b want 0", request_valid);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_basic();
        test_outstanding();
        test_round_robin();
        test_same_cycle();
        test_abort_mid();
        test_interrupt_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
